// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs one-hot instruction-class requests plus operand
// fields into 32-bit MIPS-style words and streams them into consecutive imem
// addresses. An accepted request becomes a registered write one cycle later.
module instr_encoder_loader #(
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [10:0]       in_class,
  input  logic              in_last,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_shamt,
  input  logic [4:0]        in_aluop,
  input  logic [16:0]       in_imm,
  input  logic [26:0]       in_target,
  output logic              imem_wren,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              full
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_BEX  = 5'b10110;
  localparam logic [4:0] OP_SETX = 5'b10101;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t            state;
  logic [ADDR_W-1:0] addr_cnt_p0;
  logic              class_ok_p0;
  logic [31:0]       enc_word_p0;

  // True when exactly one class bit is set.
  function automatic logic is_onehot(input logic [10:0] cls);
    return (cls != 11'd0) && ((cls & (cls - 11'd1)) == 11'd0);
  endfunction

  // Pack fields into an instruction word according to the class format.
  function automatic logic [31:0] encode(
    input logic [10:0] cls,
    input logic [4:0]  rd,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  shamt,
    input logic [4:0]  aluop,
    input logic [16:0] imm,
    input logic [26:0] target
  );
    logic [31:0] w;
    w = 32'd0;
    case (cls)
      11'b00000000001: w = {OP_LW,   rd, rs, imm};
      11'b00000000010: w = {OP_SW,   rd, rs, imm};
      11'b00000000100: w = {OP_ADDI, rd, rs, imm};
      11'b00000001000: w = {OP_ADD,  rd, rs, rt, shamt, aluop, 2'b00};
      11'b00000010000: w = {OP_J,    target};
      11'b00000100000: w = {OP_BNE,  rd, rs, imm};
      11'b00001000000: w = {OP_JAL,  target};
      11'b00010000000: w = {OP_JR,   rd, 22'd0};
      11'b00100000000: w = {OP_BLT,  rd, rs, imm};
      11'b01000000000: w = {OP_BEX,  target};
      11'b10000000000: w = {OP_SETX, target};
      default:         w = 32'd0;
    endcase
    return w;
  endfunction

  // Stage p0: classify and encode the request currently on the inputs.
  always_comb begin
    class_ok_p0 = is_onehot(in_class);
    enc_word_p0 = encode(in_class, in_rd, in_rs, in_rt, in_shamt, in_aluop,
                         in_imm, in_target);
  end

  // Stage p1: control FSM, address counter and the registered write port.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= IDLE;
      addr_cnt_p0 <= '0;
      in_ready    <= 1'b0;
      imem_wren   <= 1'b0;
      imem_addr   <= '0;
      imem_data   <= 32'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      full        <= 1'b0;
    end else begin
      imem_wren <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= LOAD;
            addr_cnt_p0 <= '0;
            in_ready    <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            err         <= 1'b0;
            full        <= 1'b0;
          end else begin
            // Any write issued on the way into DONE has drained by now.
            busy <= 1'b0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (class_ok_p0) begin
              imem_wren   <= 1'b1;
              imem_addr   <= addr_cnt_p0;
              imem_data   <= enc_word_p0;
              addr_cnt_p0 <= addr_cnt_p0 + 1'b1;
              // Final word: explicitly last, or the top address was just used.
              if (in_last || (addr_cnt_p0 == ADDR_MAX)) begin
                state    <= DONE;
                in_ready <= 1'b0;
                done     <= 1'b1;
                full     <= ~in_last;
              end
            end else begin
              // Malformed class: consume it without writing.
              err <= 1'b1;
              if (in_last) begin
                state    <= DONE;
                in_ready <= 1'b0;
                done     <= 1'b1;
                busy     <= 1'b0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader (ADDR_W=2 so wrap is reachable).
// Stimulus pushes expected writes; a monitor pops and compares on imem_wren.
module tb_instr_encoder_loader;

  localparam int AW = 2;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [10:0]   in_class = '0;
  logic          in_last = 1'b0;
  logic [4:0]    in_rd = '0, in_rs = '0, in_rt = '0, in_shamt = '0, in_aluop = '0;
  logic [16:0]   in_imm = '0;
  logic [26:0]   in_target = '0;
  logic          imem_wren;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          busy, done, err, full;

  instr_encoder_loader #(.ADDR_W(AW)) dut (
    .clock(clock), .resetn(resetn), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_class(in_class), .in_last(in_last),
    .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_shamt(in_shamt),
    .in_aluop(in_aluop), .in_imm(in_imm), .in_target(in_target),
    .imem_wren(imem_wren), .imem_addr(imem_addr), .imem_data(imem_data),
    .busy(busy), .done(done), .err(err), .full(full)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t         exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  int          n_writes = 0;
  logic [31:0] last_data = '0;

  // Reference model state
  bit m_loading = 0, m_done = 0, m_err = 0, m_full = 0;
  int m_addr = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every write must match the oldest expected entry.
  always @(negedge clock) begin
    if (imem_wren === 1'b1) begin
      n_writes++;
      last_data = imem_data;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: addr %0d data %h with nothing expected", imem_addr, imem_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(imem_addr), 32'(e.addr));
        chk("wr_data", imem_data, e.data);
        chk("wr_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  // Opcode and format derived directly from the instruction table.
  function automatic logic [31:0] ref_enc(input logic [10:0] cls, input logic [4:0] rd,
      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] sh, input logic [4:0] al,
      input logic [16:0] imm, input logic [26:0] tgt);
    longint unsigned op, v;
    int idx;
    idx = $clog2(cls);
    case (idx)
      0: op = 8;   1: op = 7;   2: op = 5;   3: op = 0;
      4: op = 1;   5: op = 2;   6: op = 3;   7: op = 4;
      8: op = 6;   9: op = 22;  default: op = 21;
    endcase
    v = op * 64'd134217728;
    if (idx == 3)
      v += rd * 64'd4194304 + rs * 64'd131072 + rt * 64'd4096 + sh * 64'd128 + al * 64'd4;
    else if (idx == 7)
      v += rd * 64'd4194304;
    else if (idx == 4 || idx == 6 || idx == 9 || idx == 10)
      v += tgt;
    else
      v += rd * 64'd4194304 + rs * 64'd131072 + imm;
    return 32'(v);
  endfunction

  task automatic check_flags(input string tag, input bit exp_busy);
    chk({tag, "_err"}, 32'(err), 32'(m_err));
    chk({tag, "_full"}, 32'(full), 32'(m_full));
    chk({tag, "_done"}, 32'(done), 32'(m_done));
    chk({tag, "_ready"}, 32'(in_ready), 32'(m_loading));
    chk({tag, "_busy"}, 32'(busy), 32'(exp_busy));
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_loading = 1; m_done = 0; m_err = 0; m_full = 0; m_addr = 0;
    chk("start_ready", 32'(in_ready), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_done", 32'(done), 32'd0);
  endtask

  // Present one request (leaves in_valid high for back-to-back use).
  task automatic send(input logic [10:0] cls, input logic [4:0] rd, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] sh, input logic [4:0] al,
      input logic [16:0] imm, input logic [26:0] tgt, input logic last);
    int n;
    bit wrote;
    in_valid = 1'b1; in_class = cls; in_last = last;
    in_rd = rd; in_rs = rs; in_rt = rt; in_shamt = sh; in_aluop = al;
    in_imm = imm; in_target = tgt;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      n_total++;
      $display("FAIL accept_timeout: in_ready %b after %0d cycles, required 1", in_ready, n);
      return;
    end
    wrote = 0;
    if ($countones(cls) != 1) begin
      m_err = 1;
      if (last) begin m_loading = 0; m_done = 1; end
    end else begin
      wr_t e;
      e.addr = m_addr; e.data = ref_enc(cls, rd, rs, rt, sh, al, imm, tgt); e.cyc = cyc + 1;
      exp_q.push_back(e);
      wrote = 1;
      if (last) begin m_loading = 0; m_done = 1; end
      else if (m_addr == DEPTH - 1) begin m_loading = 0; m_done = 1; m_full = 1; end
      m_addr = (m_addr + 1) % DEPTH;
    end
    tick();
    check_flags("send", m_loading || wrote);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    m_loading = 0; m_done = 0; m_err = 0; m_full = 0; m_addr = 0;
    exp_q.delete();
    chk("rst_wren", 32'(imem_wren), 32'd0);
    check_flags("rst", 1'b0);
    resetn = 1'b1;
  endtask

  localparam logic [10:0] C_LW = 11'd1, C_SW = 11'd2, C_ADDI = 11'd4, C_ADD = 11'd8,
                          C_J = 11'd16, C_JR = 11'd128, C_BEX = 11'd512, C_SETX = 11'd1024;

  initial begin
    int w0;
    tick();
    do_reset();
    tick();
    check_flags("idle", 1'b0);

    // Single add
    do_start();
    send(C_ADD, 5'd3, 5'd1, 5'd2, 5'd0, 5'd0, 17'd0, 27'd0, 1'b1);
    chk("add_word", last_data, 32'h00C22000);
    in_valid = 1'b0;
    tick();
    check_flags("add_after", 1'b0);

    // I-type stream, back-to-back
    do_start();
    send(C_ADDI, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'd5, 27'd0, 1'b0);
    chk("addi_word", last_data, 32'h28400005);
    send(C_SW, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd0, 1'b0);
    chk("sw_word", last_data, 32'h38400000);
    send(C_LW, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd0, 1'b1);
    chk("lw_word", last_data, 32'h40800000);
    in_valid = 1'b0;

    // Jump-format stream; start and a request together in DONE: start wins
    in_valid = 1'b1; in_class = C_LW; start = 1'b1;
    tick();
    start = 1'b0;
    m_loading = 1; m_done = 0; m_err = 0; m_full = 0; m_addr = 0;
    chk("restart_ready", 32'(in_ready), 32'd1);
    chk("restart_nowrite", 32'(imem_wren), 32'd0);
    send(C_J, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'h0000010, 1'b0);
    chk("j_word", last_data, 32'h08000010);
    send(C_JR, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd0, 1'b0);
    chk("jr_word", last_data, 32'h27C00000);
    send(C_SETX, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd7, 1'b0);
    chk("setx_word", last_data, 32'hA8000007);
    send(C_BEX, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'h100, 1'b1);
    chk("bex_word", last_data, 32'hB0000100);
    chk("bex_full", 32'(full), 32'd0);
    in_valid = 1'b0;

    // Malformed classes, then a valid lw
    do_start();
    send(11'b0, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 17'd1, 27'd0, 1'b0);
    send(11'b00000001100, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 17'd1, 27'd0, 1'b0);
    w0 = n_writes;
    send(C_LW, 5'd4, 5'd5, 5'd0, 5'd0, 5'd0, 17'h1FFFF, 27'd0, 1'b1);
    chk("err_lw_writes", 32'(n_writes - w0), 32'd1);
    in_valid = 1'b0;

    // Wrap: four non-last addi fill the memory
    do_start();
    for (int i = 0; i < DEPTH; i++)
      send(C_ADDI, 5'(i), 5'd0, 5'd0, 5'd0, 5'd0, 17'(i + 100), 27'd0, 1'b0);
    chk("wrap_full", 32'(full), 32'd1);
    w0 = n_writes;
    in_class = C_ADDI;
    for (int i = 0; i < 5; i++) tick();
    chk("wrap_nowrite", 32'(n_writes - w0), 32'd0);
    check_flags("wrap_hold", 1'b0);
    in_valid = 1'b0;

    // Reset mid-load while valid keeps streaming
    do_start();
    send(C_ADD, 5'd7, 5'd8, 5'd9, 5'd1, 5'd2, 17'd0, 27'd0, 1'b0);
    in_class = C_ADD;
    do_reset();
    in_valid = 1'b0;
    tick();
    check_flags("post_rst", 1'b0);

    // Randomized loads
    for (int l = 0; l < 25; l++) begin
      int len;
      do_start();
      len = $urandom_range(1, 6);
      for (int i = 0; i < len && m_loading; i++) begin
        logic [10:0] cls;
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) cls = '0;
        else if (r == 1) cls = 11'(1 << $urandom_range(0, 10)) | 11'(1 << $urandom_range(0, 10)) | 11'd1;
        else cls = 11'(1 << $urandom_range(0, 10));
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          tick();
        end
        send(cls, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             17'($urandom), 27'($urandom), i == len - 1);
      end
      in_valid = 1'b0;
      tick();
      check_flags("rand_end", 1'b0);
      chk("rand_drained", 32'(exp_q.size()), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
